// File: rtl/imem_block_responder.sv
// imem_block_responder: instruction-memory responder for instruction-cache refills.
// Returns a 128-bit block (4 x 32-bit words) a fixed READ_LATENCY cycles after a
// mem_read request is accepted. A 32-bit word loader fills the array whenever no
// read is pending or in flight.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   mem_read       block read request, held by the cache until mem_busywait falls
//   mem_address    block index, sampled when the request is accepted
//   mem_busywait   high while a request is pending or in flight
//   mem_ins_block  delivered block, word0 in [31:0] .. word3 in [127:96]
//   load_en        loader write strobe
//   load_addr      word address: {block, word-in-block}
//   load_word      word to write
//   load_ready     loader write accepted this cycle when high together with load_en
module imem_block_responder #(
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned BLOCK_W      = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic [ADDR_W-1:0]  mem_address,
  output logic               mem_busywait,
  output logic [BLOCK_W-1:0] mem_ins_block,
  input  logic               load_en,
  input  logic [ADDR_W+1:0]  load_addr,
  input  logic [31:0]        load_word,
  output logic               load_ready
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 4 << ADDR_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BLOCK_W-1:0]  block_q;
  logic [BLOCK_W-1:0]  block_d;
  logic [WORD_W-1:0]   mem_q [NWORDS];
  logic                load_we;

  // Word-organised array: a block is four consecutive words, so the loader's
  // word address indexes the array directly.
  always_comb begin
    block_d = {mem_q[{addr_q, 2'd3}], mem_q[{addr_q, 2'd2}],
               mem_q[{addr_q, 2'd1}], mem_q[{addr_q, 2'd0}]};
  end

  // Busy is raised combinationally in IDLE so the cache stalls in the same cycle
  // it raises mem_read; reset forces the reset-state values immediately.
  assign mem_busywait  = !reset && ((state_q == BUSY) || ((state_q == IDLE) && mem_read));
  assign load_ready    = reset || ((state_q == IDLE) && !mem_read);
  assign load_we       = load_en && load_ready && !reset;
  assign mem_ins_block = block_q;

  // Request sequencing: accept, count down the latency, deliver, one-cycle DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      block_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read) begin
            addr_q  <= mem_address;
            cnt_q   <= CNT_W'(READ_LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            block_q <= block_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (load_we) begin
      mem_q[load_addr] <= load_word;
    end
  end

endmodule

// File: tb/tb_imem_block_responder.sv
module tb_imem_block_responder;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NBLK   = 64;
  localparam int unsigned LAT    = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               mem_read, mem_read1;
  logic [ADDR_W-1:0]  mem_address;
  logic               load_en, load_en1;
  logic [ADDR_W+1:0]  load_addr;
  logic [31:0]        load_word;
  logic               busy, busy1;
  logic [127:0]       blk, blk1;
  logic               ready, ready1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents of the program image, one entry per word.
  logic [31:0] model [NBLK*4];

  always #5 clock = ~clock;

  imem_block_responder #(.READ_LATENCY(LAT), .ADDR_W(ADDR_W), .BLOCK_W(128)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_busywait(busy), .mem_ins_block(blk),
    .load_en(load_en), .load_addr(load_addr), .load_word(load_word),
    .load_ready(ready)
  );

  imem_block_responder #(.READ_LATENCY(1), .ADDR_W(ADDR_W), .BLOCK_W(128)) dut1 (
    .clock(clock), .reset(reset),
    .mem_read(mem_read1), .mem_address(mem_address),
    .mem_busywait(busy1), .mem_ins_block(blk1),
    .load_en(load_en1), .load_addr(load_addr), .load_word(load_word),
    .load_ready(ready1)
  );

  function automatic logic [127:0] exp_block(input int b);
    return {model[4*b+3], model[4*b+2], model[4*b+1], model[4*b]};
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy1 : busy;
  endfunction

  function automatic logic [127:0] blk_of(input bit sel);
    return sel ? blk1 : blk;
  endfunction

  // Loader write into both instances; callers ensure both are idle.
  task automatic do_load(input int waddr, input logic [31:0] w);
    load_en   = 1'b1;
    load_en1  = 1'b1;
    load_addr = 8'(waddr);
    load_word = w;
    @(posedge clock); #1;
    load_en  = 1'b0;
    load_en1 = 1'b0;
    model[waddr] = w;
  endtask

  // One block read: checks same-cycle busy, latency in edges after acceptance,
  // and delivered data. alt_addr >= 0 changes mem_address after acceptance;
  // drop_early releases mem_read in BUSY; keep leaves mem_read high at return.
  task automatic do_read(input bit sel, input int b, input int lat, input int alt_addr,
                         input bit drop_early, input bit keep, input string tag);
    int k;
    logic [127:0] exp;
    exp = exp_block(b);
    if (sel) mem_read1 = 1'b1; else mem_read = 1'b1;
    mem_address = 6'(b);
    @(negedge clock);
    n_checks++;
    if (busy_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_same_cycle: got %b expected 1", tag, busy_of(sel));
    end
    @(posedge clock); #1;
    if (alt_addr >= 0) mem_address = 6'(alt_addr);
    if (drop_early) begin
      if (sel) mem_read1 = 1'b0; else mem_read = 1'b0;
    end
    k = 0;
    while (busy_of(sel) === 1'b1 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    n_checks++;
    if (k != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges expected %0d", tag, k, lat);
    end
    n_checks++;
    if (blk_of(sel) !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", tag, blk_of(sel), exp);
    end
    if (!keep) begin
      if (sel) mem_read1 = 1'b0; else mem_read = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b0; mem_read1 = 1'b0; mem_address = '0;
    load_en = 1'b0; load_en1 = 1'b0; load_addr = '0; load_word = '0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || blk !== 128'd0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b blk=%h ready=%b expected 0,0,1", busy, blk, ready);
    end
    n_checks++;
    if (busy1 !== 1'b0 || blk1 !== 128'd0 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state_lat1: got busy=%b blk=%h ready=%b expected 0,0,1", busy1, blk1, ready1);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < int'(NBLK) * 4; i++) do_load(i, $urandom);
  endtask

  task automatic test_basic();
    do_load(0, 32'h11111111);
    do_load(1, 32'h22222222);
    do_load(2, 32'h33333333);
    do_load(3, 32'h44444444);
    do_read(1'b0, 0, LAT, -1, 1'b0, 1'b0, "basic");
    n_checks++;
    if (blk !== 128'h44444444_33333333_22222222_11111111) begin
      n_fail++;
      $display("FAIL basic_const: got %h expected 44444444333333332222222211111111", blk);
    end
  endtask

  task automatic test_addr_change();
    for (int w = 0; w < 4; w++) begin
      do_load(5*4 + w, $urandom);
      do_load(9*4 + w, $urandom);
    end
    do_read(1'b0, 5, LAT, 9, 1'b0, 1'b0, "addr_change");
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) begin
      do_load(63*4 + w, $urandom);
      do_load(5*4 + w, $urandom);
    end
    do_read(1'b0, 63, LAT, -1, 1'b0, 1'b1, "b2b_first");
    mem_address = 6'd5;
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b1 || blk !== exp_block(63)) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got busy=%b blk=%h expected 1,%h", busy, blk, exp_block(63));
    end
    do_read(1'b0, 5, LAT, -1, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_loader_blocked();
    int k;
    do_load(8, 32'h0BADF00D);
    mem_read = 1'b1; mem_address = 6'd2;
    load_en = 1'b1; load_addr = 8'd8; load_word = 32'hDEADBEEF;
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pending: got %b expected 0", ready);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_busy: got %b expected 0", ready);
    end
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    load_en = 1'b0; mem_read = 1'b0;
    n_checks++;
    if (k != LAT || blk !== exp_block(2)) begin
      n_fail++;
      $display("FAIL blocked_load_read: got lat=%0d blk=%h expected %0d,%h", k, blk, LAT, exp_block(2));
    end
    @(posedge clock); #1;
    load_en = 1'b1; load_en1 = 1'b1; load_addr = 8'd8; load_word = 32'hDEADBEEF;
    @(negedge clock);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_idle: got %b expected 1", ready);
    end
    @(posedge clock); #1;
    load_en = 1'b0; load_en1 = 1'b0;
    model[8] = 32'hDEADBEEF;
    do_read(1'b0, 2, LAT, -1, 1'b0, 1'b0, "loader_retry");
    n_checks++;
    if (blk[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL loader_word0: got %h expected deadbeef", blk[31:0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    mem_read = 1'b1; mem_address = 6'd9;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || blk !== 128'd0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got busy=%b blk=%h ready=%b expected 0,0,1", busy, blk, ready);
    end
    mem_read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    do_read(1'b0, 9, LAT, -1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_latency1();
    for (int i = 0; i < 6; i++)
      do_read(1'b1, int'($urandom_range(0, NBLK-1)), 1, -1, 1'(i % 2), 1'b0, "lat1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_load(int'($urandom_range(0, NBLK*4-1)), $urandom);
      else
        do_read(1'b0, int'($urandom_range(0, NBLK-1)), LAT, -1, 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_change();
    test_back_to_back();
    test_loader_blocked();
    test_reset_mid_busy();
    test_latency1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
